dac_spi_tx: RTL

Output stage directly downstream of the AM/FM modulator datapath. Consumes the modulator's S[16,15] samples and valid strobe, and buffers them in a small FIFO. Converts each sample to DAC code and serializes it as a 24-bit SPI mode-0 frame (8-bit command + 16-bit code) to an external 16-bit DAC. Absorbs bursty valid strobes and reports FIFO overflow.

---
 rtl/dac_spi_pkg.sv | 14 +
 rtl/dac_spi_tx_if.sv | 8 +
 rtl/dac_spi_tx_sync_fifo.sv | 55 +++++
 rtl/dac_spi_tx.sv | 137 +++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the DAC SPI output stage.
package dac_spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam int unsigned FRAME_BITS  = 24;
  localparam logic [7:0]  DEFAULT_CMD = 8'h30;

  // Offset-binary flips the sign bit so -32768 maps to 0x0000 and 0 to 0x8000.
  function automatic logic [15:0] to_dac_code(input logic [15:0] data, input logic offset_bin);
    return offset_bin ? {~data[15], data[14:0]} : data;
  endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample stream from the modulator into the DAC SPI transmitter.
interface dac_spi_tx_if;
  logic [15:0] id_data;
  logic        ic_val_data;

  modport master (output id_data, output ic_val_data);
  modport slave  (input  id_data, input  ic_val_data);
endinterface

// File: rtl/dac_spi_tx_sync_fifo.sv
// Synchronous FIFO with registered read data; a write into an empty FIFO
// becomes readable on the following cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign level = count;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_ok = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO is accepted.
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Buffers modulator samples and serialises each as a 24-bit SPI mode-0 frame
// ({CMD, DAC code}, MSB first) to an external 16-bit DAC.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_GAP     = 2,
  parameter logic [7:0]  CMD        = DEFAULT_CMD,
  parameter bit          OFFSET_BIN = 1'b1
) (
  input  logic                          clk,
  input  logic                          ic_rst,
  dac_spi_tx_if.slave                   smp,
  input  logic                          ic_clr_ovf,
  output logic                          oc_sclk,
  output logic                          oc_cs_n,
  output logic                          od_mosi,
  output logic                          oc_busy,
  output logic                          oc_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   od_fifo_level
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic [15:0]             fifo_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;
  logic                    div_done;
  logic                    gap_done;

  assign pop      = (state == IDLE) && !fifo_empty;
  assign div_done = (cnt == CNT_W'(CLK_DIV - 1));
  assign gap_done = (cnt == CNT_W'(CS_GAP - 1));

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (ic_rst),
    .wr_en   (smp.ic_val_data),
    .wr_data (smp.id_data),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (od_fifo_level)
  );

  always_ff @(posedge clk or posedge ic_rst) begin
    if (ic_rst) begin
      oc_overflow <= 1'b0;
    end else if (smp.ic_val_data && fifo_full && !pop) begin
      oc_overflow <= 1'b1;
    end else if (ic_clr_ovf) begin
      oc_overflow <= 1'b0;
    end
  end

  // The first bit is always CMD[7], so mosi can be driven on entry to SETUP
  // while the popped sample is still arriving from the FIFO read register.
  always_ff @(posedge clk or posedge ic_rst) begin
    if (ic_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      oc_sclk <= 1'b0;
      oc_cs_n <= 1'b1;
      od_mosi <= 1'b0;
      oc_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= SETUP;
            cnt     <= '0;
            bit_cnt <= '0;
            oc_cs_n <= 1'b0;
            oc_sclk <= 1'b0;
            od_mosi <= CMD[7];
            oc_busy <= 1'b1;
          end
        end
        SETUP: begin
          shreg <= {CMD, to_dac_code(fifo_data, OFFSET_BIN)};
          if (div_done) begin
            cnt     <= '0;
            oc_sclk <= 1'b1;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_done) begin
            cnt <= '0;
            if (oc_sclk) begin
              oc_sclk <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt != BIT_W'(FRAME_BITS - 1)) begin
                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                od_mosi <= shreg[FRAME_BITS-2];
              end
            end else if (bit_cnt == BIT_W'(FRAME_BITS)) begin
              oc_cs_n <= 1'b1;
              od_mosi <= 1'b0;
              state   <= GAP;
            end else begin
              oc_sclk <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_done) begin
            cnt     <= '0;
            oc_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
